// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//
// Bridges the single-cycle core's data port to a synchronous, single-port,
// word-wide data RAM. Executes RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW.
// Sub-word stores are done as read-modify-write. Misaligned accesses and
// illegal funct3 values are reported as a fault without touching memory.
//
// Ports:
//   CLK, RESET_N      rising-edge clock, asynchronous active-low reset
//   REQ, WE, FUNCT3   request, store/load select, RISC-V funct3
//   ADDR, WDATA       byte address and store data (held by the core until DONE)
//   RDATA             extended load result, valid with DONE, held until next load
//   DONE              one-cycle completion pulse
//   BUSY              high whenever the unit is not idle
//   FAULT             valid with DONE; misaligned or illegal access
//   MEM_ADDR          RAM word address
//   MEM_WE            RAM write enable, one cycle per store
//   MEM_WDATA         RAM write data
//   MEM_RDATA         RAM read data, valid one cycle after the address
// ---------------------------------------------------------------------------
module load_store_unit #(
    parameter int SIZE       = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic                  REQ,
    input  logic                  WE,
    input  logic [2:0]            FUNCT3,
    input  logic [SIZE-1:0]       ADDR,
    input  logic [SIZE-1:0]       WDATA,
    output logic [SIZE-1:0]       RDATA,
    output logic                  DONE,
    output logic                  BUSY,
    output logic                  FAULT,
    output logic [ADDR_WIDTH-1:0] MEM_ADDR,
    output logic                  MEM_WE,
    output logic [SIZE-1:0]       MEM_WDATA,
    input  logic [SIZE-1:0]       MEM_RDATA
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_WRITE,
        S_RESP
    } state_t;

    state_t      state;

    // Request fields captured at accept; the core holds its inputs, but the
    // unit works only from its own copies so no input reaches MEM_* directly.
    logic        we_q;
    logic [2:0]  f3_q;
    logic [1:0]  lane_q;
    logic [15:0] wdata_q;

    logic        req_legal;
    logic        req_misaligned;
    logic        req_fault;

    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;
    logic [SIZE-1:0] load_ext;
    logic [SIZE-1:0] merged;

    // Address bits above the RAM range are ignored so accesses wrap.
    logic unused_addr_bits;
    assign unused_addr_bits = ^ADDR[SIZE-1:ADDR_WIDTH+2];

    assign BUSY = (state != S_IDLE);

    // Legality and alignment of the request currently presented by the core.
    always_comb begin
        req_legal      = 1'b0;
        req_misaligned = 1'b0;
        if (WE) begin
            req_legal = (FUNCT3 inside {3'd0, 3'd1, 3'd2});
        end else begin
            req_legal = (FUNCT3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        end
        case (FUNCT3[1:0])
            2'b01:   req_misaligned = ADDR[0];
            2'b10:   req_misaligned = |ADDR[1:0];
            default: req_misaligned = 1'b0;
        endcase
        req_fault = !req_legal || req_misaligned;
    end

    // Lane extraction for loads and lane replacement for sub-word stores,
    // both working on the word returned by the RAM read.
    always_comb begin
        byte_sel = MEM_RDATA[{lane_q, 3'b000} +: 8];
        half_sel = MEM_RDATA[{lane_q[1], 4'b0000} +: 16];

        load_ext = MEM_RDATA;
        case (f3_q)
            3'd0:    load_ext = {{(SIZE-8){byte_sel[7]}}, byte_sel};
            3'd1:    load_ext = {{(SIZE-16){half_sel[15]}}, half_sel};
            3'd4:    load_ext = {{(SIZE-8){1'b0}}, byte_sel};
            3'd5:    load_ext = {{(SIZE-16){1'b0}}, half_sel};
            default: load_ext = MEM_RDATA;
        endcase

        merged = MEM_RDATA;
        if (f3_q[1:0] == 2'b00) begin
            merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            merged[{lane_q[1], 4'b0000} +: 16] = wdata_q;
        end
    end

    // Access sequencer. All outputs are registered and set on entry to the
    // state in which they must be visible, which gives the fixed latencies:
    // fault 1, SW 2, load 3, SB/SH 4 cycles from accept to DONE.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= S_IDLE;
            RDATA     <= '0;
            DONE      <= 1'b0;
            FAULT     <= 1'b0;
            MEM_WE    <= 1'b0;
            MEM_ADDR  <= '0;
            MEM_WDATA <= '0;
            we_q      <= 1'b0;
            f3_q      <= '0;
            lane_q    <= '0;
            wdata_q   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    DONE   <= 1'b0;
                    MEM_WE <= 1'b0;
                    if (REQ) begin
                        we_q    <= WE;
                        f3_q    <= FUNCT3;
                        lane_q  <= ADDR[1:0];
                        wdata_q <= WDATA[15:0];
                        if (req_fault) begin
                            FAULT <= 1'b1;
                            DONE  <= 1'b1;
                            state <= S_RESP;
                        end else begin
                            FAULT    <= 1'b0;
                            MEM_ADDR <= ADDR[ADDR_WIDTH+1:2];
                            // Full-word stores need no read, go straight to write.
                            if (WE && (FUNCT3[1:0] == 2'b10)) begin
                                MEM_WE    <= 1'b1;
                                MEM_WDATA <= WDATA;
                                state     <= S_WRITE;
                            end else begin
                                state <= S_READ;
                            end
                        end
                    end
                end
                S_READ: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (we_q) begin
                        MEM_WE    <= 1'b1;
                        MEM_WDATA <= merged;
                        state     <= S_WRITE;
                    end else begin
                        RDATA <= load_ext;
                        DONE  <= 1'b1;
                        state <= S_RESP;
                    end
                end
                S_WRITE: begin
                    MEM_WE <= 1'b0;
                    DONE   <= 1'b1;
                    state  <= S_RESP;
                end
                S_RESP: begin
                    DONE  <= 1'b0;
                    FAULT <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
//
// Drives directed and random load/store requests into load_store_unit with
// a behavioural RAM attached. Each request's expected outcome (latency,
// fault, load result, RAM write) is computed by a byte-level reference
// model and queued; an independent monitor compares DUT outputs against
// the queue whenever DONE or MEM_WE is seen.
// ---------------------------------------------------------------------------
module tb_load_store_unit;

    localparam int SIZE       = 32;
    localparam int ADDR_WIDTH = 10;
    localparam int WORDS      = 1 << ADDR_WIDTH;

    logic                  CLK     = 1'b0;
    logic                  RESET_N = 1'b1;
    logic                  REQ     = 1'b0;
    logic                  WE      = 1'b0;
    logic [2:0]            FUNCT3  = '0;
    logic [SIZE-1:0]       ADDR    = '0;
    logic [SIZE-1:0]       WDATA   = '0;
    logic [SIZE-1:0]       RDATA;
    logic                  DONE;
    logic                  BUSY;
    logic                  FAULT;
    logic [ADDR_WIDTH-1:0] MEM_ADDR;
    logic                  MEM_WE;
    logic [SIZE-1:0]       MEM_WDATA;
    logic [SIZE-1:0]       mem_rdata = '0;

    typedef struct {
        int unsigned c0;
        int unsigned lat;
        bit          fault;
        logic [31:0] rdata;
        bit          wr;
        logic [9:0]  waddr;
        logic [31:0] wdata;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] ram     [0:WORDS-1];
    logic [31:0] ref_mem [0:WORDS-1];
    logic [31:0] last_rdata = '0;
    int unsigned cyc        = 0;
    int          n_vec      = 0;
    int          n_miss     = 0;

    load_store_unit #(.SIZE(SIZE), .ADDR_WIDTH(ADDR_WIDTH)) dut (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .REQ      (REQ),
        .WE       (WE),
        .FUNCT3   (FUNCT3),
        .ADDR     (ADDR),
        .WDATA    (WDATA),
        .RDATA    (RDATA),
        .DONE     (DONE),
        .BUSY     (BUSY),
        .FAULT    (FAULT),
        .MEM_ADDR (MEM_ADDR),
        .MEM_WE   (MEM_WE),
        .MEM_WDATA(MEM_WDATA),
        .MEM_RDATA(mem_rdata)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Synchronous RAM: read-old-data, one cycle read latency.
    initial begin : ram_model
        for (int i = 0; i < WORDS; i++) ram[i] = $urandom();
        ram[5] = 32'h8070F0A5;
        forever begin
            @(posedge CLK);
            mem_rdata <= ram[MEM_ADDR];
            if (MEM_WE) ram[MEM_ADDR] = MEM_WDATA;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_miss++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Byte-level reference: an access touches nbytes consecutive bytes
    // starting at the byte offset inside word (addr/4) mod WORDS.
    function automatic exp_t refModel(input bit we, input logic [2:0] f3,
                                      input logic [31:0] addr, input logic [31:0] wd);
        exp_t        e;
        int          nbytes;
        int          off;
        int          idx;
        bit          legal;
        logic [31:0] word;
        logic [31:0] val;
        logic [31:0] mask;
        nbytes  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        off     = int'(addr % 4);
        idx     = int'((addr / 4) % WORDS);
        legal   = we ? (f3 <= 3'd2) : (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
        e.c0    = 0;
        e.fault = 1'b0;
        e.wr    = 1'b0;
        e.wdata = '0;
        e.waddr = idx[9:0];
        e.rdata = last_rdata;
        if (!legal || (off % nbytes) != 0) begin
            e.fault = 1'b1;
            e.lat   = 1;
            return e;
        end
        word = ref_mem[idx];
        if (!we) begin
            val = word >> (8 * off);
            if (nbytes < 4) begin
                mask = (32'd1 << (8 * nbytes)) - 32'd1;
                val  = val & mask;
                if (f3[2] == 1'b0 && val[8*nbytes-1]) val = val | ~mask;
            end
            last_rdata = val;
            e.rdata    = val;
            e.lat      = 3;
        end else begin
            for (int b = 0; b < nbytes; b++) word[8*(off+b) +: 8] = wd[8*b +: 8];
            ref_mem[idx] = word;
            e.wr         = 1'b1;
            e.wdata      = word;
            e.lat        = (nbytes == 4) ? 2 : 4;
        end
        return e;
    endfunction

    // Called at a falling edge with the unit idle or showing DONE; in the
    // DONE case the request stays asserted and is accepted one cycle later.
    // Returns at the falling edge where DONE is seen, leaving REQ high.
    task automatic applyStimulus(input bit we, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wd);
        exp_t e;
        bit   seen;
        e      = refModel(we, f3, addr, wd);
        e.c0   = (DONE === 1'b1) ? cyc + 1 : cyc;
        REQ    = 1'b1;
        WE     = we;
        FUNCT3 = f3;
        ADDR   = addr;
        WDATA  = wd;
        sb.push_back(e);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge CLK);
            if (DONE === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            n_vec++;
            n_miss++;
            $display("[TB] FAIL done_timeout: no DONE within 20 cycles for addr %h", addr);
            REQ = 1'b0;
        end
    endtask

    task automatic idleCycle();
        REQ = 1'b0;
        @(negedge CLK);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_rdata"},  RDATA,            32'h0);
        checkOutput({tag, "_done"},   {31'b0, DONE},    32'h0);
        checkOutput({tag, "_busy"},   {31'b0, BUSY},    32'h0);
        checkOutput({tag, "_fault"},  {31'b0, FAULT},   32'h0);
        checkOutput({tag, "_mem_we"}, {31'b0, MEM_WE},  32'h0);
        checkOutput({tag, "_maddr"},  {22'b0, MEM_ADDR}, 32'h0);
        checkOutput({tag, "_mwdata"}, MEM_WDATA,        32'h0);
    endtask

    // Monitor: matches every DONE and every MEM_WE pulse against the
    // oldest outstanding expectation.
    initial begin : monitor
        exp_t        e;
        int unsigned wcount;
        wcount = 0;
        forever begin
            @(negedge CLK);
            if (MEM_WE === 1'b1) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("[TB] FAIL stray_mem_we: MEM_WE high with no access outstanding");
                end else begin
                    checkOutput("mem_addr",  {22'b0, MEM_ADDR}, {22'b0, sb[0].waddr});
                    checkOutput("mem_wdata", MEM_WDATA, sb[0].wdata);
                    checkOutput("we_cycle",  cyc - sb[0].c0, sb[0].lat - 1);
                end
                wcount++;
            end
            if (DONE === 1'b1) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("[TB] FAIL stray_done: DONE with no access outstanding");
                end else begin
                    e = sb.pop_front();
                    checkOutput("latency",  cyc - e.c0, e.lat);
                    checkOutput("fault",    {31'b0, FAULT}, {31'b0, e.fault});
                    checkOutput("rdata",    RDATA, e.rdata);
                    checkOutput("we_count", wcount, {31'b0, e.wr});
                    checkOutput("busy_at_done", {31'b0, BUSY}, 32'h1);
                end
                wcount = 0;
            end
        end
    end

    initial begin : stimulus
        logic [31:0] a;
        int          bad;
        #2 RESET_N = 1'b0;
        #1 checkResetOutputs("reset");
        for (int i = 0; i < WORDS; i++) ref_mem[i] = ram[i];
        last_rdata = '0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RESET_N = 1'b1;

        // Loads on 0x8070F0A5 at word 5.
        applyStimulus(1'b0, 3'd0, 32'h14, 32'h0); checkOutput("lb_14", RDATA, 32'hFFFFFFA5); idleCycle();
        applyStimulus(1'b0, 3'd0, 32'h15, 32'h0); checkOutput("lb_15", RDATA, 32'hFFFFFFF0); idleCycle();
        applyStimulus(1'b0, 3'd0, 32'h17, 32'h0); checkOutput("lb_17", RDATA, 32'hFFFFFF80); idleCycle();
        applyStimulus(1'b0, 3'd4, 32'h15, 32'h0); checkOutput("lbu_15", RDATA, 32'h000000F0); idleCycle();
        applyStimulus(1'b0, 3'd5, 32'h16, 32'h0); checkOutput("lhu_16", RDATA, 32'h00008070); idleCycle();
        applyStimulus(1'b0, 3'd1, 32'h16, 32'h0); checkOutput("lh_16", RDATA, 32'hFFFF8070); idleCycle();
        applyStimulus(1'b0, 3'd2, 32'h14, 32'h0); checkOutput("lw_14", RDATA, 32'h8070F0A5); idleCycle();

        // Sub-word stores, then read back.
        applyStimulus(1'b1, 3'd0, 32'h15, 32'h123456CC); idleCycle();
        applyStimulus(1'b1, 3'd1, 32'h16, 32'h0000BEEF); idleCycle();
        applyStimulus(1'b0, 3'd2, 32'h14, 32'h0); checkOutput("lw_after_sbsh", RDATA, 32'hBEEFCCA5); idleCycle();

        // SW followed back-to-back by LW of the same word.
        applyStimulus(1'b1, 3'd2, 32'h20, 32'hDEADBEEF);
        applyStimulus(1'b0, 3'd2, 32'h20, 32'h0); checkOutput("lw_20", RDATA, 32'hDEADBEEF); idleCycle();

        // Faults: misaligned LW, misaligned SH, illegal load funct3.
        applyStimulus(1'b0, 3'd2, 32'h22, 32'h0); idleCycle();
        applyStimulus(1'b1, 3'd1, 32'h13, 32'h5555AAAA); idleCycle();
        applyStimulus(1'b0, 3'd3, 32'h14, 32'h0);
        checkOutput("rdata_kept_after_faults", RDATA, 32'hDEADBEEF); idleCycle();

        // Reset pulsed while an SB waits for its read data.
        REQ = 1'b1; WE = 1'b1; FUNCT3 = 3'd0; ADDR = 32'h15; WDATA = 32'h00000011;
        @(posedge CLK);
        @(posedge CLK);
        #2 RESET_N = 1'b0;
        REQ = 1'b0;
        #1 checkResetOutputs("reset_mid");
        last_rdata = '0;
        @(posedge CLK);
        @(negedge CLK);
        RESET_N = 1'b1;
        applyStimulus(1'b0, 3'd2, 32'h14, 32'h0); checkOutput("lw_after_reset", RDATA, 32'hBEEFCCA5); idleCycle();

        // Random mix over a small word window with random upper address bits.
        for (int n = 0; n < 120; n++) begin
            a = $urandom() & 32'hFFFF_F03F;
            applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom());
            if ($urandom_range(0, 1) == 0) idleCycle();
        end
        idleCycle();
        repeat (3) @(negedge CLK);

        checkOutput("scoreboard_drained", sb.size(), 32'h0);
        bad = 0;
        for (int i = 0; i < WORDS; i++) if (ram[i] !== ref_mem[i]) bad++;
        checkOutput("ram_words_differing", bad, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the single-cycle core's data port and a synchronous single-port word-wide data RAM.
- Executes LB/LH/LW/LBU/LHU/SB/SH/SW.
  - Sign/zero-extends load data.
  - Merges sub-word stores with a read-modify-write sequence.
  - Flags misaligned or illegal accesses.
- Core stalls its PC while BUSY is high and consumes RDATA on the DONE pulse.

Parameters:
- SIZE, 32, data width in bits; byte lanes fixed at SIZE/8 = 4.
- ADDR_WIDTH, 10, RAM word-address width; RAM holds 2^ADDR_WIDTH words.

Ports:
- CLK  input  1  clock, rising edge.
- RESET_N  input  1  asynchronous, active-low reset.
- REQ  input  1  access request; core holds REQ, WE, FUNCT3, ADDR and WDATA stable until DONE.
- WE  input  1  1 = store, 0 = load.
- FUNCT3  input  3  RISC-V funct3 of the load/store.
- ADDR  input  SIZE  byte address from the core ALU.
- WDATA  input  SIZE  store data (rs2).
- RDATA  output  SIZE  extended load result; valid while DONE=1.
- DONE  output  1  one-cycle completion pulse.
- BUSY  output  1  high whenever state != IDLE.
- FAULT  output  1  valid with DONE; 1 = misaligned or illegal funct3, no memory access performed.
- MEM_ADDR  output  ADDR_WIDTH  RAM word address = latched ADDR[ADDR_WIDTH+1:2].
- MEM_WE  output  1  RAM write enable.
- MEM_WDATA  output  SIZE  RAM write data.
- MEM_RDATA  input  SIZE  RAM read data; valid one cycle after the address is presented with MEM_WE=0.

Behaviour:
- Reset (asynchronous):
  - state=IDLE.
  - RDATA=0, DONE=0, BUSY=0, FAULT=0, MEM_WE=0, MEM_ADDR=0, MEM_WDATA=0.
  - Reset asserted mid-operation aborts the access; no write is issued after reset. A MEM_WE already high drops immediately.
- Outputs are driven only from registered state and latched request fields. There is no combinational path from REQ/ADDR to MEM_*.
- States and transitions:
  - IDLE: on REQ, latch WE/FUNCT3/ADDR/WDATA and check legality.
    - Legal loads: funct3 0,1,2,4,5. Legal stores: 0,1,2.
    - Alignment: halfword requires ADDR[0]=0; word requires ADDR[1:0]=0.
    - Illegal or misaligned -> RESP with FAULT=1.
    - SW -> WRITE.
    - Any load, SB or SH -> READ.
    - A REQ arriving in the cycle after DONE is accepted normally as a new request.
  - READ: MEM_ADDR=word address, MEM_WE=0 -> WAIT.
  - WAIT: MEM_RDATA valid.
    - Load: RDATA <= extracted lane, sign-extended (LB/LH) or zero-extended (LBU/LHU) -> RESP.
    - SB/SH: merge register <= MEM_RDATA with the selected byte/halfword lane replaced by WDATA[7:0]/[15:0] -> WRITE.
  - WRITE: MEM_WE=1; MEM_WDATA = WDATA (SW) or merge register -> RESP.
  - RESP: DONE=1 for exactly one cycle, FAULT per check -> IDLE.
- Lane selection: byte lane = ADDR[1:0]; halfword lane = ADDR[1]; little-endian.
- Latency from the REQ-accepting cycle (cycle 0) to the DONE cycle:
  - Faulted: 1.
  - SW: 2.
  - Loads: 3.
  - SB/SH: 4.
- RDATA holds its value after DONE until the next load completes. On a store or fault it holds its previous value.
- Address bits above ADDR_WIDTH+1 are ignored, so accesses wrap modulo RAM size.
- MEM_WE is high for exactly one cycle per store and never high on a faulted or load access.

Test Plan:
- Reset, RAM[5]=0x8070F0A5; LB at ADDR 0x14, then 0x15, then 0x17 -> RDATA 0xFFFFFFA5, 0xFFFFFFF0, 0xFFFFFF80; DONE 3 cycles after each accept; MEM_WE never asserted.
- LBU 0x15 -> 0x000000F0; LHU 0x16 -> 0x00008070; LH 0x16 -> 0xFFFF8070; LW 0x14 -> 0x8070F0A5.
- SB ADDR 0x15 WDATA 0x123456CC on RAM[5]=0x8070F0A5 -> one MEM_WE pulse, MEM_ADDR 5, MEM_WDATA 0x8070CCA5; DONE 4 cycles after accept. SH 0x16 WDATA 0xBEEF -> 0xBEEFCCA5.
- SW ADDR 0x20 WDATA 0xDEADBEEF -> MEM_WE in cycle 1, MEM_ADDR 8, DONE at cycle 2; following LW 0x20 returns 0xDEADBEEF.
- Misaligned LW 0x22, misaligned SH 0x13, and load with FUNCT3=3 -> DONE+FAULT at cycle 1, MEM_WE stays 0, RAM unchanged, RDATA unchanged.
- RESET_N pulsed low during WAIT of an SB -> outputs return to reset values immediately, no MEM_WE pulse, RAM word unchanged; next LW after release completes normally. Back-to-back REQ held after DONE -> second access accepted the next cycle.
